// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR: FSM states, width helpers,
// and the round/saturate step applied to the accumulator.
package fir_pkg;

  localparam int RND_W = 64;

  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index widths for the default 2-channel, 101-tap configuration.
  localparam int CH_W  = ch_bits(2);
  localparam int TAP_W = $clog2(101);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_ROUND,
    S_OUT
  } fir_state_t;

  typedef struct packed {
    logic signed [RND_W-1:0] value;
    logic                    sat;
  } rnd_t;

  // Round half-up, arithmetic shift, then clip to a signed data_w range.
  function automatic rnd_t sat_round(input logic signed [RND_W-1:0] acc,
                                     input int frac_bits, input int data_w);
    logic signed [RND_W-1:0] r;
    logic signed [RND_W-1:0] hi;
    logic signed [RND_W-1:0] lo;
    rnd_t res;
    if (frac_bits > 0) r = (acc + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
    else               r = acc;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (r > hi) begin
      res.value = hi;
      res.sat   = 1'b1;
    end else if (r < lo) begin
      res.value = lo;
      res.sat   = 1'b1;
    end else begin
      res.value = r;
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_hist_ram.sv
// Per-channel circular sample history with one write port at the channel's
// write pointer and one combinational read port addressed by tap offset.
module fir_hist_ram
  import fir_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int TAPS     = 101,
  parameter int CHANNELS = 2,
  parameter int CW       = 1,
  parameter int TW       = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [CW-1:0]            wr_chan,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     adv,
  input  logic [CW-1:0]            rd_chan,
  input  logic [TW-1:0]            rd_off,
  output logic signed [DATA_W-1:0] rd_data
);

  localparam logic [TW-1:0] LAST = TW'(TAPS - 1);

  logic signed [DATA_W-1:0] mem [CHANNELS][TAPS];
  logic [TW-1:0]            wr_ptr [CHANNELS];
  logic [TW-1:0]            base;
  logic [TW-1:0]            rd_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        wr_ptr[c] <= '0;
        for (int unsigned t = 0; t < TAPS; t++) mem[c][t] <= '0;
      end
    end else begin
      if (we) mem[wr_chan][wr_ptr[wr_chan]] <= wr_data;
      if (adv) wr_ptr[rd_chan] <= (wr_ptr[rd_chan] == LAST) ? '0 : wr_ptr[rd_chan] + 1'b1;
    end
  end

  // Modulo-TAPS subtraction; when TAPS is a power of two TW'(TAPS) is 0 and the
  // natural TW-bit wrap gives the same result.
  always_comb begin
    base = wr_ptr[rd_chan];
    if (base >= rd_off) rd_idx = base - rd_off;
    else                rd_idx = base + TW'(TAPS) - rd_off;
  end

  assign rd_data = mem[rd_chan][rd_idx];

endmodule

// File: rtl/fir_tdm_mac.sv
// Multi-channel signed FIR sharing a single MAC across channels, with
// double-buffered coefficients and ready/valid on both sides.
module fir_tdm_mac
  import fir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 101,
  parameter int CHANNELS  = 2,
  parameter int ACC_W     = 48,
  parameter int FRAC_BITS = 15,
  localparam int CW       = ch_bits(CHANNELS),
  localparam int TW       = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_sample,
  input  logic [CW-1:0]            in_chan,
  input  logic                     coef_we,
  input  logic [TW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     coef_swap,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_sample,
  output logic [CW-1:0]            out_chan,
  output logic                     out_sat
);

  localparam logic [TW-1:0] K_LAST = TW'(TAPS - 1);

  fir_state_t                      state;
  logic [CW-1:0]                   ch;
  logic [TW-1:0]                   k;
  logic signed [ACC_W-1:0]         acc;
  logic                            swap_pend;
  logic signed [COEF_W-1:0]        active [TAPS];
  logic signed [COEF_W-1:0]        shadow [TAPS];
  logic signed [COEF_W-1:0]        shadow_nxt [TAPS];
  logic signed [DATA_W-1:0]        hist_q;
  logic signed [DATA_W+COEF_W-1:0] prod;
  rnd_t                            rnd;
  logic                            accept;
  logic                            chan_ok;
  logic                            last_tap;
  logic                            swap_now;

  assign accept   = in_valid && in_ready && (state == S_IDLE);
  assign chan_ok  = int'(in_chan) < CHANNELS;
  assign last_tap = (k == K_LAST);
  assign swap_now = (state == S_IDLE) && (swap_pend || coef_swap);

  fir_hist_ram #(
    .DATA_W   (DATA_W),
    .TAPS     (TAPS),
    .CHANNELS (CHANNELS),
    .CW       (CW),
    .TW       (TW)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .we      (accept && chan_ok),
    .wr_chan (in_chan),
    .wr_data (in_sample),
    .adv     ((state == S_MAC) && last_tap),
    .rd_chan (ch),
    .rd_off  (k),
    .rd_data (hist_q)
  );

  // A same-cycle write is merged first so a simultaneous swap carries it.
  always_comb begin
    shadow_nxt = shadow;
    if (coef_we && (int'(coef_addr) < TAPS)) shadow_nxt[coef_addr] = coef_data;
  end

  always_comb begin
    prod = hist_q * active[k];
    rnd  = sat_round(RND_W'(acc), FRAC_BITS, DATA_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_chan   <= '0;
      out_sat    <= 1'b0;
      ch         <= '0;
      k          <= '0;
      acc        <= '0;
      swap_pend  <= 1'b0;
      for (int unsigned t = 0; t < TAPS; t++) begin
        active[t] <= '0;
        shadow[t] <= '0;
      end
    end else begin
      shadow <= shadow_nxt;
      if (swap_now) begin
        active    <= shadow_nxt;
        swap_pend <= 1'b0;
      end else if (coef_swap) begin
        swap_pend <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (accept && chan_ok) begin
            ch       <= in_chan;
            acc      <= '0;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + ACC_W'(prod);
          if (last_tap) state <= S_ROUND;
          else          k <= k + 1'b1;
        end
        S_ROUND: begin
          out_sample <= rnd.value[DATA_W-1:0];
          out_sat    <= rnd.sat;
          out_chan   <= ch;
          state      <= S_OUT;
        end
        S_OUT: begin
          // Result registers settle in ROUND; valid is raised one edge later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tdm_mac.sv
// Directed bench for fir_tdm_mac in a 4-tap, 2-channel configuration.
module tb_fir_tdm_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_sample = '0;
  logic [0:0]  in_chan = '0;
  logic        coef_we = 1'b0;
  logic [1:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic        coef_swap = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sample;
  logic [0:0]  out_chan;
  logic        out_sat;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fir_tdm_mac #(
    .DATA_W    (16),
    .COEF_W    (16),
    .TAPS      (4),
    .CHANNELS  (2),
    .ACC_W     (48),
    .FRAC_BITS (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .in_chan    (in_chan),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_swap  (coef_swap),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .out_chan   (out_chan),
    .out_sat    (out_sat)
  );

  typedef struct {
    logic        load;
    logic [15:0] coef;
    logic [0:0]  chan;
    logic [15:0] sample;
    logic [15:0] exp;
    logic        exp_sat;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic load, input logic [15:0] coef, input logic [0:0] chan,
                              input logic [15:0] sample, input logic [15:0] exp, input logic exp_sat);
    vec_t v;
    v.load = load; v.coef = coef; v.chan = chan;
    v.sample = sample; v.exp = exp; v.exp_sat = exp_sat;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic load_coefs(input logic [15:0] v, input logic do_swap);
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      coef_we = 1'b1; coef_addr = 2'(a); coef_data = v;
    end
    @(negedge clk);
    coef_we = 1'b0; coef_swap = do_swap;
    @(negedge clk);
    coef_swap = 1'b0;
  endtask

  // One sample in, one result out; lat counts edges from accept to out_valid.
  task automatic xfer(input logic [0:0] c, input logic [15:0] s, input int swap_at,
                      output logic [15:0] o, output logic [0:0] oc, output logic osat,
                      output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 64'(n < 50), 64'd1);
    in_valid = 1'b1; in_chan = c; in_sample = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      coef_swap = (swap_at > 0) && (lat == swap_at);
      @(posedge clk); #1;
      lat++;
    end
    coef_swap = 1'b0;
    o = out_sample; oc = out_chan; osat = out_sat;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] o;
    logic [0:0]  oc;
    logic        osat;
    int          lat;
    int          n;
    logic        stable;
    logic        seen;
    logic [15:0] held;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sample", 64'(out_sample), 64'd0);
    check("rst_out_chan", 64'(out_chan), 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Impulse on ch0 with 0.5 coefficients
    add(1, 16'h4000, 0, 16'h7FFF, 16'h4000, 0);
    add(0, 16'h0000, 0, 16'h0000, 16'h4000, 0);
    add(0, 16'h0000, 0, 16'h0000, 16'h4000, 0);
    add(0, 16'h0000, 0, 16'h0000, 16'h4000, 0);
    add(0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    // Interleaved channels must stay independent
    add(0, 16'h0000, 0, 16'h7FFF, 16'h4000, 0);
    add(0, 16'h0000, 1, 16'h0000, 16'h0000, 0);
    add(0, 16'h0000, 0, 16'h0000, 16'h4000, 0);
    add(0, 16'h0000, 1, 16'h0000, 16'h0000, 0);
    add(0, 16'h0000, 0, 16'h0000, 16'h4000, 0);
    add(0, 16'h0000, 1, 16'h0000, 16'h0000, 0);
    add(0, 16'h0000, 0, 16'h0000, 16'h4000, 0);
    add(0, 16'h0000, 1, 16'h0000, 16'h0000, 0);
    add(0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    add(0, 16'h0000, 1, 16'h0000, 16'h0000, 0);
    // Full-scale coefficients drive positive then negative saturation
    add(1, 16'h7FFF, 0, 16'h7FFF, 16'h7FFE, 0);
    add(0, 16'h0000, 0, 16'h7FFF, 16'h7FFF, 1);
    add(0, 16'h0000, 0, 16'h7FFF, 16'h7FFF, 1);
    add(0, 16'h0000, 0, 16'h7FFF, 16'h7FFF, 1);
    add(0, 16'h0000, 0, 16'h8000, 16'h7FFF, 1);
    add(0, 16'h0000, 0, 16'h8000, 16'hFFFE, 0);
    add(0, 16'h0000, 0, 16'h8000, 16'h8000, 1);
    add(0, 16'h0000, 0, 16'h8000, 16'h8000, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].load) load_coefs(tbl[i].coef, 1'b1);
      xfer(tbl[i].chan, tbl[i].sample, 0, o, oc, osat, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd6);
      check($sformatf("vec%0d_sample", i), 64'(o), 64'(tbl[i].exp));
      check($sformatf("vec%0d_chan", i), 64'(oc), 64'(tbl[i].chan));
      check($sformatf("vec%0d_sat", i), 64'(osat), 64'(tbl[i].exp_sat));
    end

    // Backpressure: result held while out_ready is low
    @(negedge clk);
    in_valid = 1'b1; in_chan = 1'b1; in_sample = 16'h4000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_latency", 64'(n), 64'd6);
    check("bp_sample", 64'(out_sample), 64'h4000);
    check("bp_chan", 64'(out_chan), 64'd1);
    held = out_sample;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!out_valid || out_sample !== held || out_chan !== 1'b1 || in_ready) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_released", 64'(out_valid), 64'd0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("bp_single_result", 64'(seen), 64'd0);
    check("bp_in_ready", 64'(in_ready), 64'd1);

    // Swap requested mid-MAC takes effect only for the next sample
    load_coefs(16'h4000, 1'b1);
    for (int i = 0; i < 4; i++) xfer(0, 16'h0000, 0, o, oc, osat, lat);
    load_coefs(16'h2000, 1'b0);
    xfer(0, 16'h7FFF, 2, o, oc, osat, lat);
    check("swap_old_bank", 64'(o), 64'h4000);
    check("swap_latency", 64'(lat), 64'd6);
    xfer(0, 16'h0000, 0, o, oc, osat, lat);
    check("swap_new_bank", 64'(o), 64'h2000);
    xfer(0, 16'h0000, 0, o, oc, osat, lat);
    check("swap_new_bank2", 64'(o), 64'h2000);

    // Reset mid-MAC discards the in-flight sample and clears coefficients
    @(negedge clk);
    in_valid = 1'b1; in_chan = 1'b0; in_sample = 16'h7FFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", 64'(in_ready), 64'd0);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("rst_no_stale", 64'(seen), 64'd0);
    xfer(0, 16'h7FFF, 0, o, oc, osat, lat);
    check("rst_impulse_sample", 64'(o), 64'h0000);
    check("rst_impulse_latency", 64'(lat), 64'd6);
    xfer(0, 16'h0000, 0, o, oc, osat, lat);
    check("rst_zero_sample", 64'(o), 64'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
